mesh_switch_allocator: RTL and testbench
========================================

// Module: mesh_switch_allocator
// PURPOSE
//  Per-output switch allocator for the 5-port mesh router: shares each output
//  port (N,E,S,W,Local) among input FIFO heads and drives crossbar selects/pops.
//  Wormhole semantics: an output is locked to one input from head flit to tail
//  flit. Round-robin fairness per output. Sits between the routing logic
//  (supplies destination port) and the crossbar/output registers.
// PARAMETERS
//  NUM_PORTS  5  number of router ports (inputs = outputs); indices 0..NUM_PORTS-1
//  SEL_W      3  width of a port index; must satisfy 2**SEL_W >= NUM_PORTS
// PORTS
//  clk        in   1                  router clock
//  rst        in   1                  synchronous reset, active-high
//  req_valid  in   NUM_PORTS          input i FIFO head holds a flit
//  req_dst    in   NUM_PORTS*SEL_W    dest output of input i head, slice [i*SEL_W +: SEL_W]
//  req_head   in   NUM_PORTS          input i head flit is a packet head
//  req_tail   in   NUM_PORTS          input i head flit is a packet tail (head&tail = 1-flit pkt)
//  out_ready  in   NUM_PORTS          downstream of output o accepts a flit this cycle
//  grant      out  NUM_PORTS*NUM_PORTS one-hot owner of output o, slice [o*NUM_PORTS +: NUM_PORTS]
//  xbar_sel   out  NUM_PORTS*SEL_W    encoded owner of output o (0 when no owner)
//  out_valid  out  NUM_PORTS          output o carries a valid flit this cycle
//  in_pop     out  NUM_PORTS          pop input i FIFO (flit accepted downstream)
//  locked     out  NUM_PORTS          output o mid-packet (registered)
//  err_dst    out  1                  sticky: valid request with req_dst >= NUM_PORTS seen
// BEHAVIOUR
//  - Per-output state (registered): IDLE / LOCKED(owner); rr_ptr[o] (SEL_W bits).
//  - Reset: all outputs IDLE, rr_ptr=0, locked=0, err_dst=0; while rst=1 grant,
//    xbar_sel, out_valid, in_pop forced 0. Reset mid-packet drops the lock; no recovery.
//  - Candidate for output o: input i with req_valid[i] && req_dst[i]==o.
//  - IDLE: only candidates with req_head=1 compete; non-head candidates ignored.
//    Winner = first candidate scanning i = rr_ptr[o], rr_ptr[o]+1, ... mod NUM_PORTS.
//    Grant is combinational, same cycle (0-cycle allocation latency).
//  - LOCKED(k): grant = k regardless of other requests; all others wait.
//  - out_valid[o] = owner exists && req_valid[owner] && req_dst[owner]==o.
//    Owner valid low while LOCKED = bubble: lock held, out_valid=0, no pop.
//  - Flit accepted on output o when out_valid[o] && out_ready[o]; then in_pop[owner]=1.
//    No acceptance -> grant held next cycle (IDLE re-arbitrates with unchanged ptr).
//  - On accepted head: rr_ptr[o] <= (owner+1) mod NUM_PORTS.
//    head&!tail -> LOCKED(owner); head&tail -> stay IDLE.
//  - LOCKED, accepted tail -> IDLE next cycle. Accepted head while LOCKED: protocol
//    violation, treated as body flit (lock kept).
//  - Each input requests one output, so at most one in_pop per input per cycle;
//    up to NUM_PORTS outputs may transfer in the same cycle.
//  - req_dst >= NUM_PORTS with req_valid: matches no output, never popped;
//    err_dst set next cycle, cleared only by rst.
//  - Wrap: rr_ptr increment from NUM_PORTS-1 returns to 0.
// TESTING
//  1 Reset then inputs 1,3 head+tail to output 2, out_ready=all 1 -> cycle0 grant
//    input1 (ptr 0), cycle1 input3, ptr[2]=4 after.
//  2 Input0 4-flit pkt to out1, input4 1-flit to out1 arriving cycle1 -> input4
//    waits until cycle after input0 tail pop; locked[1]=1 for cycles 1..3.
//  3 Locked owner drops req_valid 2 cycles mid-packet -> out_valid=0, no pops,
//    grant unchanged, no other input granted.
//  4 out_ready[3]=0 for 3 cycles with input2 head pending -> grant held,
//    in_pop=0, rr_ptr unchanged; pops on first ready cycle.
//  5 All 5 inputs target distinct outputs, all ready -> 5 simultaneous pops.
//  6 req_dst=7 on input0 -> err_dst=1 next cycle, never popped; rst mid-packet
//    -> locked=0, rr_ptr=0, err_dst=0 after reset.

Source files
------------

// File: rtl/mesh_switch_allocator.sv
// Per-output switch allocator for a mesh router. Each output port is shared
// among the input FIFO heads with round-robin arbitration on packet heads and
// wormhole locking from head flit to tail flit. Grants, crossbar selects, output
// valids and input pops are combinational (0-cycle allocation latency).
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | output free; head-flit candidates arbitrate from rr_ptr
// ST_LOCKED  | output owned by owner_q until the owner's tail flit is accepted
module mesh_switch_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int SEL_W     = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PORTS-1:0]           req_valid_i,
    input  logic [NUM_PORTS*SEL_W-1:0]     req_dst_i,
    input  logic [NUM_PORTS-1:0]           req_head_i,
    input  logic [NUM_PORTS-1:0]           req_tail_i,
    input  logic [NUM_PORTS-1:0]           out_ready_i,
    output logic [NUM_PORTS*NUM_PORTS-1:0] grant_o,
    output logic [NUM_PORTS*SEL_W-1:0]     xbar_sel_o,
    output logic [NUM_PORTS-1:0]           out_valid_o,
    output logic [NUM_PORTS-1:0]           in_pop_o,
    output logic [NUM_PORTS-1:0]           locked_o,
    output logic                           err_dst_o
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic [NUM_PORTS-1:0] state_q, state_d;
    logic [SEL_W-1:0]     owner_q  [NUM_PORTS];
    logic [SEL_W-1:0]     owner_d  [NUM_PORTS];
    logic [SEL_W-1:0]     rr_ptr_q [NUM_PORTS];
    logic [SEL_W-1:0]     rr_ptr_d [NUM_PORTS];
    logic                 err_dst_q, err_dst_d;

    logic [SEL_W-1:0]     own_c [NUM_PORTS];
    logic [NUM_PORTS-1:0] has_own_c;
    logic [NUM_PORTS-1:0] accept_c;

    // Pick the owner of each output: the locked owner, or the first head-flit
    // candidate at or after rr_ptr when idle.
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            has_own_c[o] = 1'b0;
            own_c[o]     = '0;
            if (state_q[o] == ST_LOCKED) begin
                has_own_c[o] = 1'b1;
                own_c[o]     = owner_q[o];
            end else begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = int'(rr_ptr_q[o]) + k;
                    if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                    if (!has_own_c[o] && req_valid_i[idx] && req_head_i[idx] &&
                        req_dst_i[idx*SEL_W +: SEL_W] == SEL_W'(o)) begin
                        has_own_c[o] = 1'b1;
                        own_c[o]     = SEL_W'(idx);
                    end
                end
            end
        end
    end

    // Drive grant/select/valid/pop from the chosen owners; reset blanks them.
    always_comb begin
        int  own_i;
        logic ov;
        own_i       = 0;
        ov          = 1'b0;
        grant_o     = '0;
        xbar_sel_o  = '0;
        out_valid_o = '0;
        in_pop_o    = '0;
        accept_c    = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (has_own_c[o]) begin
                own_i       = int'(own_c[o]);
                ov          = req_valid_i[own_i] &&
                              req_dst_i[own_i*SEL_W +: SEL_W] == SEL_W'(o);
                accept_c[o] = ov && out_ready_i[o];
                if (!rst_i) begin
                    grant_o[o*NUM_PORTS + own_i]  = 1'b1;
                    xbar_sel_o[o*SEL_W +: SEL_W]  = own_c[o];
                    out_valid_o[o]                = ov;
                    if (accept_c[o]) in_pop_o[own_i] = 1'b1;
                end
            end
        end
    end

    // Advance lock state and round-robin pointers on accepted flits; latch bad destinations.
    always_comb begin
        int own_i;
        own_i     = 0;
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        err_dst_d = err_dst_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_valid_i[i] && int'(req_dst_i[i*SEL_W +: SEL_W]) >= NUM_PORTS)
                err_dst_d = 1'b1;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (accept_c[o]) begin
                own_i = int'(own_c[o]);
                if (state_q[o] == ST_IDLE) begin
                    // Only heads win in IDLE, so this flit is a packet head.
                    rr_ptr_d[o] = (own_i == NUM_PORTS-1) ? '0 : SEL_W'(own_i + 1);
                    if (!req_tail_i[own_i]) begin
                        state_d[o] = ST_LOCKED;
                        owner_d[o] = own_c[o];
                    end
                end else if (req_tail_i[own_i]) begin
                    state_d[o] = ST_IDLE;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= '0;
            err_dst_q <= 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
            end
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            err_dst_q <= err_dst_d;
        end
    end

    assign locked_o  = state_q;
    assign err_dst_o = err_dst_q;

endmodule

// File: tb/tb_mesh_switch_allocator.sv
// Directed bench for mesh_switch_allocator: a vector table for arbitration,
// wormhole and parallel-transfer cases, then hand-written stall/bubble/error/
// reset sequences.
module tb_mesh_switch_allocator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  req_valid = '0;
    logic [14:0] req_dst = '0;
    logic [4:0]  req_head = '0;
    logic [4:0]  req_tail = '0;
    logic [4:0]  out_ready = '0;
    logic [24:0] grant;
    logic [14:0] xbar_sel;
    logic [4:0]  out_valid;
    logic [4:0]  in_pop;
    logic [4:0]  locked;
    logic        err_dst;

    int passed = 0;
    int total  = 0;

    mesh_switch_allocator #(.NUM_PORTS(5), .SEL_W(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_dst_i   (req_dst),
        .req_head_i  (req_head),
        .req_tail_i  (req_tail),
        .out_ready_i (out_ready),
        .grant_o     (grant),
        .xbar_sel_o  (xbar_sel),
        .out_valid_o (out_valid),
        .in_pop_o    (in_pop),
        .locked_o    (locked),
        .err_dst_o   (err_dst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  valid;
        logic [14:0] dst;
        logic [4:0]  head;
        logic [4:0]  tail;
        logic [4:0]  ready;
        logic [14:0] own;   // expected owner per output, 7 = no owner
        logic [4:0]  ov;
        logic [4:0]  pop;
        logic [4:0]  lck;
        logic        err;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [14:0] mk3(input int a0, input int a1, input int a2,
                                        input int a3, input int a4);
        return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        else
            passed++;
    endtask

    // Drive one cycle of inputs, check all outputs before the edge, then clock.
    task automatic step(input string nm, input logic [4:0] v, input logic [14:0] d,
                        input logic [4:0] h, input logic [4:0] t, input logic [4:0] r,
                        input logic [14:0] own, input logic [4:0] ov, input logic [4:0] pop,
                        input logic [4:0] lck, input logic err);
        logic [24:0] eg;
        logic [14:0] es;
        logic [2:0]  ow;
        req_valid = v; req_dst = d; req_head = h; req_tail = t; out_ready = r;
        eg = '0;
        es = '0;
        for (int o = 0; o < 5; o++) begin
            ow = own[o*3 +: 3];
            if (ow != 3'd7) begin
                eg[o*5 + int'(ow)] = 1'b1;
                es[o*3 +: 3] = ow;
            end
        end
        #1;
        cmp({nm, ".grant"},     32'(grant),     32'(eg));
        cmp({nm, ".xbar_sel"},  32'(xbar_sel),  32'(es));
        cmp({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
        cmp({nm, ".in_pop"},    32'(in_pop),    32'(pop));
        cmp({nm, ".locked"},    32'(locked),    32'(lck));
        cmp({nm, ".err_dst"},   32'(err_dst),   32'(err));
        @(posedge clk);
        #1;
    endtask

    localparam logic [4:0] ALL = 5'b11111;

    initial begin
        logic [14:0] none;
        none = mk3(7, 7, 7, 7, 7);

        // Inputs 1,3 head+tail to output 2; ptr[2] wraps through 2 and 4.
        vecs[0]  = '{5'b01010, mk3(0,2,0,2,0), 5'b01010, 5'b01010, ALL, mk3(7,7,1,7,7), 5'b00100, 5'b00010, 5'b0, 1'b0};
        vecs[1]  = '{5'b01000, mk3(0,0,0,2,0), 5'b01000, 5'b01000, ALL, mk3(7,7,3,7,7), 5'b00100, 5'b01000, 5'b0, 1'b0};
        vecs[2]  = '{5'b11000, mk3(0,0,0,2,2), 5'b11000, 5'b11000, ALL, mk3(7,7,4,7,7), 5'b00100, 5'b10000, 5'b0, 1'b0};
        vecs[3]  = '{5'b01000, mk3(0,0,0,2,0), 5'b01000, 5'b01000, ALL, mk3(7,7,3,7,7), 5'b00100, 5'b01000, 5'b0, 1'b0};
        // Input0 4-flit packet to output 1, input4 single flit waits for the tail.
        vecs[4]  = '{5'b00001, mk3(1,0,0,0,0), 5'b00001, 5'b00000, ALL, mk3(7,0,7,7,7), 5'b00010, 5'b00001, 5'b00000, 1'b0};
        vecs[5]  = '{5'b10001, mk3(1,0,0,0,1), 5'b10000, 5'b10000, ALL, mk3(7,0,7,7,7), 5'b00010, 5'b00001, 5'b00010, 1'b0};
        vecs[6]  = '{5'b10001, mk3(1,0,0,0,1), 5'b10000, 5'b10000, ALL, mk3(7,0,7,7,7), 5'b00010, 5'b00001, 5'b00010, 1'b0};
        vecs[7]  = '{5'b10001, mk3(1,0,0,0,1), 5'b10000, 5'b10001, ALL, mk3(7,0,7,7,7), 5'b00010, 5'b00001, 5'b00010, 1'b0};
        vecs[8]  = '{5'b10000, mk3(0,0,0,0,1), 5'b10000, 5'b10000, ALL, mk3(7,4,7,7,7), 5'b00010, 5'b10000, 5'b00000, 1'b0};
        vecs[9]  = '{5'b00000, mk3(0,0,0,0,0), 5'b00000, 5'b00000, ALL, none,           5'b00000, 5'b00000, 5'b00000, 1'b0};
        // Five inputs to five distinct outputs: all transfer together.
        vecs[10] = '{ALL,      mk3(3,4,0,1,2), ALL,      ALL,      ALL, mk3(2,3,4,0,1), ALL,      ALL,      5'b00000, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        // Requests present during reset must not be granted.
        step("reset", 5'b01010, mk3(0,2,0,2,0), 5'b01010, 5'b01010, ALL, none, 5'b0, 5'b0, 5'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].dst, vecs[i].head, vecs[i].tail,
                 vecs[i].ready, vecs[i].own, vecs[i].ov, vecs[i].pop, vecs[i].lck, vecs[i].err);

        // Bubble: owner input2 on output 0 drops valid for 2 cycles while input1 waits.
        step("bub0", 5'b00100, mk3(0,0,0,0,0), 5'b00100, 5'b00000, ALL, mk3(2,7,7,7,7), 5'b00001, 5'b00100, 5'b00000, 1'b0);
        step("bub1", 5'b00010, mk3(0,0,0,0,0), 5'b00010, 5'b00010, ALL, mk3(2,7,7,7,7), 5'b00000, 5'b00000, 5'b00001, 1'b0);
        step("bub2", 5'b00010, mk3(0,0,0,0,0), 5'b00010, 5'b00010, ALL, mk3(2,7,7,7,7), 5'b00000, 5'b00000, 5'b00001, 1'b0);
        step("bub3", 5'b00110, mk3(0,0,0,0,0), 5'b00010, 5'b00110, ALL, mk3(2,7,7,7,7), 5'b00001, 5'b00100, 5'b00001, 1'b0);
        step("bub4", 5'b00010, mk3(0,0,0,0,0), 5'b00010, 5'b00010, ALL, mk3(1,7,7,7,7), 5'b00001, 5'b00010, 5'b00000, 1'b0);

        // Output 3 stalled 3 cycles; input0 also waiting proves ptr[3]=1 is untouched.
        for (int c = 0; c < 3; c++)
            step($sformatf("stall%0d", c), 5'b00101, mk3(3,0,3,0,0), 5'b00101, 5'b00101, 5'b10111,
                 mk3(7,7,7,2,7), 5'b01000, 5'b00000, 5'b00000, 1'b0);
        step("stall3", 5'b00101, mk3(3,0,3,0,0), 5'b00101, 5'b00101, ALL, mk3(7,7,7,2,7), 5'b01000, 5'b00100, 5'b00000, 1'b0);
        step("stall4", 5'b00001, mk3(3,0,0,0,0), 5'b00001, 5'b00001, ALL, mk3(7,7,7,0,7), 5'b01000, 5'b00001, 5'b00000, 1'b0);

        // Bad destination on input0, then a lock on output 4, then reset mid-packet.
        step("err0", 5'b00001, mk3(7,0,0,0,0), 5'b00001, 5'b00001, ALL, none, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        step("err1", 5'b01001, mk3(7,0,0,4,0), 5'b01001, 5'b00001, ALL, mk3(7,7,7,7,3), 5'b10000, 5'b01000, 5'b00000, 1'b1);
        step("err2", 5'b01001, mk3(7,0,0,4,0), 5'b00001, 5'b00001, ALL, mk3(7,7,7,7,3), 5'b10000, 5'b01000, 5'b10000, 1'b1);
        rst = 1'b1;
        step("rst_mid", 5'b01000, mk3(0,0,0,4,0), 5'b00000, 5'b00000, ALL, none, 5'b00000, 5'b00000, 5'b10000, 1'b1);
        rst = 1'b0;
        // Lock dropped (input3 body ignored) and ptr[0]=0 so input1 beats input4.
        step("post0", 5'b11010, mk3(0,0,0,4,0), 5'b10010, 5'b10010, ALL, mk3(1,7,7,7,7), 5'b00001, 5'b00010, 5'b00000, 1'b0);
        step("post1", 5'b00000, mk3(0,0,0,0,0), 5'b00000, 5'b00000, ALL, none, 5'b00000, 5'b00000, 5'b00000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
